// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_hs data memory: funct3 codes, FSM states,
// and helpers that decode access size and legality from funct3.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

   // Access size in bytes; the unsigned variants share the low two bits with
   // their signed counterparts.
   function automatic logic [3:0] f3_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 4'd1;
         2'b01:   return 4'd2;
         2'b10:   return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

   function automatic logic f3_legal(input logic [2:0] f3, input logic we,
                                     input logic is64);
      case (f3)
         F3_B, F3_H, F3_W: return 1'b1;
         F3_D:             return is64;
         F3_BU, F3_HU:     return !we;
         F3_WU:            return is64 && !we;
         default:          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane helper: store byte mask and data shift, load extract and extend.
// Purely combinational so the cache fill path can share it.
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   localparam int NB = DATA_WIDTH / 8,
   localparam int OFF_W = $clog2(NB)
) (
   input  logic [2:0]            funct3,
   input  logic [OFF_W-1:0]      offset,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rword,
   output logic [NB-1:0]         byte_mask,
   output logic [DATA_WIDTH-1:0] wdata_shift,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] shifted;
   int off_i;
   int size_i;

   always_comb begin
      off_i  = int'(offset);
      size_i = int'(f3_size(funct3));
      byte_mask = '0;
      for (int i = 0; i < NB; i++) begin
         if (i >= off_i && i < off_i + size_i) byte_mask[i] = 1'b1;
      end
   end

   assign wdata_shift = wdata << {offset, 3'b000};
   assign shifted     = rword >> {offset, 3'b000};

   always_comb begin
      rdata = '0;
      case (funct3)
         F3_B:    rdata = DATA_WIDTH'($signed(shifted[7:0]));
         F3_H:    rdata = DATA_WIDTH'($signed(shifted[15:0]));
         F3_W:    rdata = DATA_WIDTH'($signed(shifted[31:0]));
         F3_D:    rdata = shifted;
         F3_BU:   rdata = DATA_WIDTH'(shifted[7:0]);
         F3_HU:   rdata = DATA_WIDTH'(shifted[15:0]);
         F3_WU:   rdata = DATA_WIDTH'(shifted[31:0]);
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/dmem_hs.sv
// Data memory with valid/ready request and response channels, one access in
// flight. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module dmem_hs
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_SIZE    = 64,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(MEM_SIZE);
   localparam int AQ_W  = OFF_W + IDX_W;

   state_t                state;
   logic [3:0]            cnt;
   logic                  we_q;
   logic [2:0]            f3_q;
   logic [AQ_W-1:0]       addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

   logic [IDX_W-1:0]      idx;
   logic [OFF_W-1:0]      raw_off;
   logic [OFF_W-1:0]      size_m1;
   logic [OFF_W-1:0]      eff_off;
   logic                  mis_err;
   logic                  acc_err;
   logic [NB-1:0]         byte_mask;
   logic [DATA_WIDTH-1:0] wdata_shift;
   logic [DATA_WIDTH-1:0] ld_data;

   // Address bits above the array wrap silently.
   logic unused_addr;
   assign unused_addr = ^req_addr[ADDR_WIDTH-1:AQ_W];

   assign idx     = addr_q[OFF_W +: IDX_W];
   assign raw_off = addr_q[OFF_W-1:0];
   assign size_m1 = OFF_W'(f3_size(f3_q) - 4'd1);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign eff_off = raw_off;
   assign mis_err = |(raw_off & size_m1);
`else
   assign eff_off = raw_off & ~size_m1;
   assign mis_err = 1'b0;
`endif

   assign acc_err = !f3_legal(f3_q, we_q, DATA_WIDTH == 64) || mis_err;

   dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .funct3      (f3_q),
      .offset      (eff_off),
      .wdata       (wdata_q),
      .rword       (mem[idx]),
      .byte_mask   (byte_mask),
      .wdata_shift (wdata_shift),
      .rdata       (ld_data)
   );

   // A reset landing on the ACCESS edge cancels the store.
   always_ff @(posedge clk) begin
      if (!reset && state == ACCESS && we_q && !acc_err) begin
         for (int i = 0; i < NB; i++) begin
            if (byte_mask[i]) mem[idx][8*i +: 8] <= wdata_shift[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         we_q      <= 1'b0;
         f3_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  f3_q      <= req_funct3;
                  addr_q    <= req_addr[AQ_W-1:0];
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  if (WAIT_STATES > 0) begin
                     state <= WAIT;
                     cnt   <= 4'(WAIT_STATES - 1);
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) state <= ACCESS;
               else             cnt   <= cnt - 4'd1;
            end
            ACCESS: begin
               rsp_err   <= acc_err;
               rsp_rdata <= (acc_err || we_q) ? '0 : ld_data;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_hs.sv
// Drives an RV32 (no wait states) and an RV64 (3 wait states) instance with
// shared stimulus and checks both against a byte-array reference model.
module tb_dmem_hs;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, req_valid, req_we, rsp_ready;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_ready, rsp_valid, rsp_err;
   logic [31:0] rd32;
   logic [63:0] rd64;

   int checks = 0;
   int errors = 0;

   logic [7:0] mb [2][512];

   dmem_hs #(.DATA_WIDTH(32), .WAIT_STATES(0)) u32 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata[31:0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
      .rsp_rdata(rd32), .rsp_err(rsp_err[0]));

   dmem_hs #(.DATA_WIDTH(64), .WAIT_STATES(3)) u64 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
      .rsp_rdata(rd64), .rsp_err(rsp_err[1]));

   function automatic int ws_of(input int d);
      return (d == 1) ? 3 : 0;
   endfunction

   // Reference: memory as a flat byte array, accesses by byte address.
   task automatic model(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [63:0] wd,
                        output logic e, output logic [63:0] rd);
      int nb, wb, ba;
      logic legal;
      wb = (d == 1) ? 8 : 4;
      case (f3)
         3'd0, 3'd4: nb = 1;
         3'd1, 3'd5: nb = 2;
         3'd2, 3'd6: nb = 4;
         default:    nb = 8;
      endcase
      legal = (f3 <= 3'd2) || (f3 == 3'd3 && d == 1) ||
              (!we && (f3 == 3'd4 || f3 == 3'd5)) || (!we && f3 == 3'd6 && d == 1);
      ba = int'(a % (64 * wb));
      e  = !legal;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (ba % nb != 0) e = 1'b1;
`else
      ba = ba - (ba % nb);
`endif
      rd = '0;
      if (!e) begin
         if (we) begin
            for (int i = 0; i < nb; i++) mb[d][ba+i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < nb; i++) rd[8*i +: 8] = mb[d][ba+i];
            if (f3 < 3'd4 && nb < 8 && rd[8*nb-1])
               for (int i = 8*nb; i < 64; i++) rd[i] = 1'b1;
         end
      end
   endtask

   task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [63:0] wd, input int hold,
                         output logic [31:0] o32, output logic [63:0] o64);
      logic        ee [2];
      logic [63:0] er [2];
      logic [63:0] exp_rd;
      logic [63:0] got_rd [2];
      logic        got_e [2];
      int          lat [2];
      model(0, we, f3, a, wd, ee[0], er[0]);
      model(1, we, f3, a, wd, ee[1], er[1]);
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      req_valid = 1'b1; rsp_ready = (hold == 0);
      checks++;
      if (req_ready !== 2'b11) begin
         errors++; $display("FAIL req_ready_idle: got %b want 11", req_ready);
      end
      @(posedge clk); #1 req_valid = 1'b0;
      lat = '{-1, -1};
      got_rd = '{'x, 'x};
      got_e = '{1'bx, 1'bx};
      for (int k = 1; k <= 40 && (lat[0] < 0 || lat[1] < 0); k++) begin
         @(negedge clk);
         if (lat[0] < 0 && rsp_valid[0]) begin
            lat[0] = k; got_rd[0] = {32'h0, rd32}; got_e[0] = rsp_err[0];
         end
         if (lat[1] < 0 && rsp_valid[1]) begin
            lat[1] = k; got_rd[1] = rd64; got_e[1] = rsp_err[1];
         end
      end
      for (int d = 0; d < 2; d++) begin
         exp_rd = (d == 1) ? er[1] : {32'h0, er[0][31:0]};
         checks++;
         if (lat[d] != 2 + ws_of(d)) begin
            errors++; $display("FAIL latency dut%0d f3=%0d a=%h: got %0d want %0d", d, f3, a, lat[d], 2 + ws_of(d));
         end
         checks++;
         if (got_e[d] !== ee[d]) begin
            errors++; $display("FAIL rsp_err dut%0d we=%b f3=%0d a=%h: got %b want %b", d, we, f3, a, got_e[d], ee[d]);
         end
         checks++;
         if (got_rd[d] !== exp_rd) begin
            errors++; $display("FAIL rsp_rdata dut%0d we=%b f3=%0d a=%h: got %h want %h", d, we, f3, a, got_rd[d], exp_rd);
         end
      end
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b11 || req_ready !== 2'b00 ||
                rd32 !== got_rd[0][31:0] || rd64 !== got_rd[1]) begin
               errors++; $display("FAIL hold_stable: valid=%b ready=%b rd32=%h rd64=%h want valid=11 ready=00 rd32=%h rd64=%h",
                                  rsp_valid, req_ready, rd32, rd64, got_rd[0][31:0], got_rd[1]);
            end
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (rsp_valid !== 2'b00) begin
            errors++; $display("FAIL rsp_drop: got %b want 00", rsp_valid);
         end
      end
      o32 = got_rd[0][31:0];
      o64 = got_rd[1];
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b11 || rsp_valid !== 2'b00 || rsp_err !== 2'b00 ||
          rd32 !== 32'h0 || rd64 !== 64'h0) begin
         errors++; $display("FAIL reset_state: ready=%b valid=%b err=%b rd32=%h rd64=%h want 11 00 00 0 0",
                            req_ready, rsp_valid, rsp_err, rd32, rd64);
      end
      reset = 1'b0;
   endtask

   task automatic test_init();
      logic [31:0] o32; logic [63:0] o64;
      for (int a = 0; a < 512; a += 4)
         do_txn(1'b1, F3_W, a, {32'h0, $urandom}, 0, o32, o64);
   endtask

   task automatic test_basic();
      logic [31:0] o32; logic [63:0] o64;
      do_txn(1'b1, F3_W, 32'h10, 64'hDEADBEEF, 0, o32, o64);
      do_txn(1'b0, F3_W, 32'h10, 64'h0, 0, o32, o64);
      checks++;
      if (o32 !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_basic: got %h want deadbeef", o32); end
      do_txn(1'b1, F3_W, 32'h10, 64'h11223344, 0, o32, o64);
      do_txn(1'b1, F3_B, 32'h13, 64'h80, 0, o32, o64);
      do_txn(1'b0, F3_B, 32'h13, 64'h0, 0, o32, o64);
      checks++;
      if (o32 !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext: got %h want ffffff80", o32); end
      do_txn(1'b0, F3_BU, 32'h13, 64'h0, 0, o32, o64);
      checks++;
      if (o32 !== 32'h00000080) begin errors++; $display("FAIL lbu_zext: got %h want 00000080", o32); end
      do_txn(1'b0, F3_W, 32'h10, 64'h0, 0, o32, o64);
      checks++;
      if (o32 !== 32'h80223344) begin errors++; $display("FAIL sb_merge: got %h want 80223344", o32); end
      do_txn(1'b1, F3_W, 32'h10, 64'hABCD1234, 0, o32, o64);
      do_txn(1'b0, F3_H, 32'h12, 64'h0, 4, o32, o64);
      checks++;
      if (o32 !== 32'hFFFFABCD) begin errors++; $display("FAIL lh_hold: got %h want ffffabcd", o32); end
      do_txn(1'b1, F3_D, 32'h8, 64'h0123456789ABCDEF, 0, o32, o64);
      do_txn(1'b0, F3_WU, 32'hC, 64'h0, 0, o32, o64);
      checks++;
      if (o64 !== 64'h0000000001234567) begin errors++; $display("FAIL lwu_64: got %h want 0000000001234567", o64); end
   endtask

   task automatic test_misalign();
      logic [31:0] o32; logic [63:0] o64;
      do_txn(1'b0, F3_W, 32'h11, 64'h0, 0, o32, o64);
      checks++;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (o32 !== 32'h0) begin errors++; $display("FAIL lw_misalign: got %h want 00000000", o32); end
`else
      if (o32 !== 32'hABCD1234) begin errors++; $display("FAIL lw_misalign: got %h want abcd1234", o32); end
`endif
      do_txn(1'b1, F3_H, 32'h21, 64'hFFFF, 0, o32, o64);
      do_txn(1'b0, F3_W, 32'h20, 64'h0, 0, o32, o64);
   endtask

   task automatic test_illegal();
      logic [31:0] o32; logic [63:0] o64;
      do_txn(1'b0, 3'b111, 32'h10, 64'h0, 0, o32, o64);
      do_txn(1'b1, F3_BU, 32'h10, 64'h5555555555555555, 0, o32, o64);
      do_txn(1'b0, F3_W, 32'h10, 64'h0, 0, o32, o64);
      checks++;
      if (o32 !== 32'hABCD1234) begin errors++; $display("FAIL illegal_nowrite: got %h want abcd1234", o32); end
   endtask

   task automatic test_alias();
      logic [31:0] o32; logic [63:0] o64;
      do_txn(1'b1, F3_W, 32'h100, 64'hCAFEF00D, 0, o32, o64);
      do_txn(1'b0, F3_W, 32'h0, 64'h0, 0, o32, o64);
      checks++;
      if (o32 !== 32'hCAFEF00D) begin errors++; $display("FAIL alias_word0: got %h want cafef00d", o32); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] o32; logic [63:0] o64;
      logic e; logic [63:0] r;
      model(0, 1'b1, F3_D, 32'h8, 64'hFEEDFACE00C0FFEE, e, r);
      @(negedge clk);
      req_we = 1'b1; req_funct3 = F3_D; req_addr = 32'h8; req_wdata = 64'hFEEDFACE00C0FFEE;
      req_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00 || req_ready !== 2'b11) begin
         errors++; $display("FAIL reset_mid: valid=%b ready=%b want 00 11", rsp_valid, req_ready);
      end
      reset = 1'b0;
      do_txn(1'b0, F3_D, 32'h8, 64'h0, 0, o32, o64);
      checks++;
      if (o64 !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL reset_nocommit: got %h want 0123456789abcdef", o64); end
   endtask

   task automatic test_random();
      logic [31:0] o32; logic [63:0] o64;
      for (int n = 0; n < 300; n++)
         do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 1023)),
                {$urandom, $urandom}, ($urandom_range(0, 9) == 0) ? 2 : 0, o32, o64);
   endtask

   initial begin
      test_reset();
      test_init();
      test_basic();
      test_misalign();
      test_illegal();
      test_alias();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
